// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache, one 32-bit word per frame, IDLE/FETCH fill FSM
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs.
module icache_dm #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX  = $clog2(NSETS);
    localparam int TAGW = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t           r_state;
    logic [NSETS-1:0] r_valid;
    logic [TAGW-1:0]  r_tag  [NSETS];
    logic [31:0]      r_data [NSETS];
    logic [31:0]      r_miss_addr;

    logic [IDX-1:0]   w_index;
    logic [IDX-1:0]   w_fill_index;
    logic [TAGW-1:0]  w_tag;
    logic             w_hit;
    logic             w_miss;
    logic             w_fill;
    logic             w_unused;

    assign w_index      = imemaddr[IDX+1:2];
    assign w_tag        = imemaddr[31:IDX+2];
    assign w_fill_index = r_miss_addr[IDX+1:2];
    assign w_unused     = &{1'b0, imemaddr[1:0]};

    // Hits are only served while idle; inv masks both hit and miss detection.
    assign w_hit  = (r_state == IDLE) && imemREN && !inv
                    && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss = (r_state == IDLE) && imemREN && !inv && !w_hit;
    assign w_fill = (r_state == FETCH) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_index] : 32'h0;
    assign iREN     = (r_state == FETCH);
    assign iaddr    = (r_state == FETCH) ? r_miss_addr : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_miss_addr <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_miss_addr <= {imemaddr[31:2], 2'b00};
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_state               <= IDLE;
                    end
                end
            endcase
            // Placed last so an invalidate overrides a fill completing on the same edge.
            if (inv) begin
                r_valid <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill && !RST) begin
            r_tag[w_fill_index]  <= r_miss_addr[31:IDX+2];
            r_data[w_fill_index] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (w_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (w_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter: NSETS, 16, number of direct-mapped one-word frames (power of two, 2..256).
REQ-002 SHALL have port: CLK  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: imemREN  in  1  datapath instruction read request.
REQ-005 SHALL have port: imemaddr  in  32  datapath fetch byte address (PC).
REQ-006 SHALL have port: ihit  out  1  instruction valid on imemload this cycle.
REQ-007 SHALL have port: imemload  out  32  instruction word.
REQ-008 SHALL have port: inv  in  1  invalidate all frames.
REQ-009 SHALL have port: iREN  out  1  memory read request.
REQ-010 SHALL have port: iaddr  out  32  memory word address.
REQ-011 SHALL have port: iwait  in  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0.
REQ-012 SHALL have port: iload  in  32  memory read data.

Function
REQ-013 SHALL decode imemaddr as offset [1:0] (ignored), index [IDX+1:2] with IDX=log2(NSETS), tag [31:IDX+2].
REQ-014 SHALL hold per frame: valid (1), tag (30-IDX), data (32).
REQ-015 SHALL implement FSM states IDLE and FETCH only.
REQ-016 In IDLE, ihit SHALL be combinational: imemREN & !inv & valid[index] & tag match; imemload = data[index] on hit, else 0.
REQ-017 In IDLE, a request that misses (imemREN=1, no hit, inv=0) SHALL latch imemaddr word-aligned into miss_addr and move to FETCH at the next edge.
REQ-018 In FETCH, iREN SHALL be 1, iaddr SHALL equal miss_addr, ihit SHALL be 0; in IDLE iREN=0, iaddr=0.
REQ-019 FETCH SHALL remain while iwait=1; on an edge with iwait=0 it SHALL write valid=1, tag, data=iload into the frame of miss_addr and return to IDLE.
REQ-020 Miss latency: with iwait=0 on the first FETCH cycle, ihit SHALL assert in the second cycle after the miss was detected (miss cycle, FETCH cycle, hit cycle).
REQ-021 A fill in progress SHALL NOT be aborted by a change of imemaddr or deassertion of imemREN; the new address is evaluated in IDLE after the fill.
REQ-022 A fill SHALL replace any prior frame contents regardless of prior valid/tag (no replacement policy beyond direct mapping).
REQ-023 inv=1 SHALL clear all valid bits at the next edge; if coincident with a fill-completing edge, the filled frame SHALL also end invalid (inv wins).
REQ-024 inv=1 in IDLE SHALL suppress miss detection for that cycle.
REQ-025 imemREN=0 in IDLE SHALL give ihit=0 and no state change.

Reset
REQ-026 RST=1 at an edge SHALL force state IDLE, all valid bits 0, miss_addr 0; tag/data arrays need not be cleared.
REQ-027 Outputs after reset SHALL be ihit=0, imemload=0, iREN=0, iaddr=0; RST during FETCH SHALL abandon the fill with no frame written.

Configuration
REQ-028 Macro ICACHE_STATS_EN SHALL, when defined, add outputs hit_count (out 32) and miss_count (out 32), reset to 0, incremented on each IDLE cycle with ihit=1 and on each IDLE->FETCH transition respectively, wrapping at 2^32.
REQ-029 Without ICACHE_STATS_EN the counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-030 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0, iload=0x3C010004 -> iREN=1/iaddr=0x40 for 4 cycles, then ihit=1, imemload=0x3C010004.
REQ-031 Conflict: fill 0x00000000 (data 0xAAAA0000), then request 0x00000040 (same index, NSETS=16) -> miss, refill; re-request 0x00000000 -> miss again.
REQ-032 Address change mid-fill: miss on 0x100, switch imemaddr to 0x104 during FETCH with iwait=1 -> iaddr stays 0x100; after fill, 0x104 misses and fetches.
REQ-033 Invalidate: warm frame at 0x8, assert inv one cycle -> ihit=0 that cycle; next request to 0x8 misses; inv on fill-completing edge leaves frame invalid.
REQ-034 Reset mid-fill: RST during FETCH -> next cycle iREN=0; request of same address misses.
REQ-035 With ICACHE_STATS_EN: 1 cold miss then 5 hit cycles at same address -> miss_count=1, hit_count=5.
